// File: rtl/free_tag_alloc.sv
// free_tag_alloc: pool of N = 2**LG_N tags tracked by a free bitmap.
// Each cycle the lowest free tag is offered combinationally. A returned tag
// becomes grantable again from the following cycle.
// Optional double-free detection is built when FREE_TAG_DBL_FREE_CHECK_EN is defined.
//
// Handshake: alloc_req/alloc_gnt are valid/ready style with zero latency.
// A tag is consumed in every cycle where alloc_req=1 and alloc_gnt=1, and
// alloc_tag is meaningful only in such a cycle. free_valid has no back-pressure:
// a return is always accepted unless flush or reset is high in that cycle.
module free_tag_alloc #(
  parameter int LG_N = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc_req,
  output logic            alloc_gnt,
  output logic [LG_N-1:0] alloc_tag,
  input  logic            free_valid,
  input  logic [LG_N-1:0] free_tag,
  input  logic            flush,
  output logic            empty,
  output logic [LG_N:0]   free_cnt,
  output logic            dbl_free_err
);

  localparam int N = 1 << LG_N;

  logic [N-1:0]  bitmap;
  logic [N-1:0]  bitmap_nxt;
  logic [N-1:0]  gnt_mask;
  logic [N-1:0]  free_mask;
  logic          free_accept;
  logic          free_new;
  logic [LG_N:0] cnt_nxt;

  // Priority encoder: lowest-numbered free tag, 0 when none is free.
  always_comb begin
    alloc_tag = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bitmap[i]) alloc_tag = LG_N'(i);
    end
  end

  // Grant qualified by the registered empty flag so the request path stays short.
  assign alloc_gnt   = alloc_req & ~empty & ~flush & ~reset;
  assign free_accept = free_valid & ~flush;
  // A return only counts when the tag is currently held; freeing a free tag is a no-op.
  assign free_new    = free_accept & ~bitmap[free_tag];

  // Next bitmap and count: the return is applied first, then the grant clears its bit.
  always_comb begin
    gnt_mask   = '0;
    free_mask  = '0;
    if (alloc_gnt) gnt_mask  = N'(1) << alloc_tag;
    if (free_new)  free_mask = N'(1) << free_tag;
    bitmap_nxt = (bitmap | free_mask) & ~gnt_mask;
    cnt_nxt    = free_cnt - (LG_N + 1)'(alloc_gnt) + (LG_N + 1)'(free_new);
  end

  // Pool state register; reset and flush both restore the full pool.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      bitmap   <= '1;
      free_cnt <= (LG_N + 1)'(N);
      empty    <= 1'b0;
    end else begin
      bitmap   <= bitmap_nxt;
      free_cnt <= cnt_nxt;
      empty    <= (cnt_nxt == '0);
    end
  end

`ifdef FREE_TAG_DBL_FREE_CHECK_EN
  // Sticky double-free flag; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbl_free_err <= 1'b0;
    end else if (free_accept && bitmap[free_tag]) begin
      dbl_free_err <= 1'b1;
    end
  end
`else
  assign dbl_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_free_tag_alloc.sv
// Testbench for free_tag_alloc (LG_N = 4). The reference model keeps one
// "is free" flag per tag and derives count, lowest tag and grant by plain
// arithmetic. Honours FREE_TAG_DBL_FREE_CHECK_EN for the error flag.
module tb_free_tag_alloc;

  localparam int LG_N = 4;
  localparam int N    = 1 << LG_N;
`ifdef FREE_TAG_DBL_FREE_CHECK_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  // Clock and reset signals
  logic            clk = 1'b0;
  logic            reset;
  logic            alloc_req;
  logic            alloc_gnt;
  logic [LG_N-1:0] alloc_tag;
  logic            free_valid;
  logic [LG_N-1:0] free_tag;
  logic            flush;
  logic            empty;
  logic [LG_N:0]   free_cnt;
  logic            dbl_free_err;

  always #5 clk = ~clk;

  free_tag_alloc #(.LG_N(LG_N)) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_tag    (alloc_tag),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .flush        (flush),
    .empty        (empty),
    .free_cnt     (free_cnt),
    .dbl_free_err (dbl_free_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  bit m_free[N];
  bit m_err;

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_free[i]);
    return c;
  endfunction

  function automatic int m_low();
    for (int i = 0; i < N; i++) if (m_free[i]) return i;
    return 0;
  endfunction

  function automatic bit m_gnt();
    return alloc_req && (m_cnt() != 0) && !flush && !reset;
  endfunction

  // Driver: apply inputs just after a rising edge, then move to the sampling point.
  task automatic drive(input bit rq, input bit fv, input int ft, input bit fl, input bit rs);
    alloc_req  = rq;
    free_valid = fv;
    free_tag   = LG_N'(ft);
    flush      = fl;
    reset      = rs;
    @(negedge clk);
  endtask

  // Advance the model with the inputs of this cycle, then cross the rising edge.
  task automatic advance();
    bit g;
    int t;
    g = m_gnt();
    t = m_low();
    if (reset) begin
      for (int i = 0; i < N; i++) m_free[i] = 1'b1;
      m_err = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) m_free[i] = 1'b1;
    end else begin
      if (free_valid) begin
        if (m_free[free_tag]) m_err = m_err | DBL_EN;
        else m_free[free_tag] = 1'b1;
      end
      if (g) m_free[t] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 1);
    advance();
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0);
      advance();
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 1);
    checks++;
    if (alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt got %b exp 0", alloc_gnt);
    end
    advance();
    drive(1, 0, 0, 0, 1);
    checks++;
    if (free_cnt !== (LG_N+1)'(N) || empty !== 1'b0 || dbl_free_err !== 1'b0 || alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d empty=%b err=%b gnt=%b exp cnt=%0d empty=0 err=0 gnt=0",
               free_cnt, empty, dbl_free_err, alloc_gnt, N);
    end
    advance();
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) begin
      drive(1, 0, 0, 0, 0);
      checks++;
      if (alloc_gnt !== 1'b1 || alloc_tag !== LG_N'(i)) begin
        errors++;
        $display("FAIL fill_gnt[%0d] got gnt=%b tag=%0d exp gnt=1 tag=%0d", i, alloc_gnt, alloc_tag, i);
      end
      advance();
    end
    drive(1, 0, 0, 0, 0);
    checks++;
    if (empty !== 1'b1 || free_cnt !== '0 || alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fill_empty got empty=%b cnt=%0d gnt=%b exp empty=1 cnt=0 gnt=0", empty, free_cnt, alloc_gnt);
    end
    advance();
  endtask

  task automatic test_free_latency();
    drive(1, 1, 5, 0, 0);
    checks++;
    if (alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL free_bypass got gnt=%b exp 0", alloc_gnt);
    end
    advance();
    drive(1, 0, 0, 0, 0);
    checks++;
    if (alloc_gnt !== 1'b1 || alloc_tag !== LG_N'(5)) begin
      errors++;
      $display("FAIL free_regrant got gnt=%b tag=%0d exp gnt=1 tag=5", alloc_gnt, alloc_tag);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_n(4);
    drive(1, 1, 2, 0, 0);
    checks++;
    if (alloc_gnt !== 1'b1 || alloc_tag !== LG_N'(4) || free_cnt !== (LG_N+1)'(12)) begin
      errors++;
      $display("FAIL simul_gnt got gnt=%b tag=%0d cnt=%0d exp gnt=1 tag=4 cnt=12", alloc_gnt, alloc_tag, free_cnt);
    end
    advance();
    drive(1, 0, 0, 0, 0);
    checks++;
    if (alloc_gnt !== 1'b1 || alloc_tag !== LG_N'(2) || free_cnt !== (LG_N+1)'(12)) begin
      errors++;
      $display("FAIL simul_next got gnt=%b tag=%0d cnt=%0d exp gnt=1 tag=2 cnt=12", alloc_gnt, alloc_tag, free_cnt);
    end
    advance();
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(10);
    drive(1, 1, 3, 1, 0);
    checks++;
    if (alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL flush_gnt got %b exp 0", alloc_gnt);
    end
    advance();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (free_cnt !== (LG_N+1)'(N) || empty !== 1'b0 || alloc_tag !== '0) begin
      errors++;
      $display("FAIL flush_state got cnt=%0d empty=%b tag=%0d exp cnt=%0d empty=0 tag=0", free_cnt, empty, alloc_tag, N);
    end
    advance();
  endtask

  task automatic test_dbl_free();
    do_reset();
    drive(0, 1, 7, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (dbl_free_err !== DBL_EN || free_cnt !== (LG_N+1)'(N)) begin
      errors++;
      $display("FAIL dbl_set got err=%b cnt=%0d exp err=%b cnt=%0d", dbl_free_err, free_cnt, DBL_EN, N);
    end
    advance();
    drive(0, 0, 0, 1, 0);
    advance();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (dbl_free_err !== DBL_EN) begin
      errors++;
      $display("FAIL dbl_sticky got err=%b exp %b", dbl_free_err, DBL_EN);
    end
    advance();
    do_reset();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (dbl_free_err !== 1'b0) begin
      errors++;
      $display("FAIL dbl_clear got err=%b exp 0", dbl_free_err);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_n(6);
    drive(1, 1, 1, 0, 1);
    checks++;
    if (alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_gnt got %b exp 0", alloc_gnt);
    end
    advance();
    drive(1, 0, 0, 0, 0);
    checks++;
    if (free_cnt !== (LG_N+1)'(N) || alloc_gnt !== 1'b1 || alloc_tag !== '0) begin
      errors++;
      $display("FAIL rstmid_state got cnt=%0d gnt=%b tag=%0d exp cnt=%0d gnt=1 tag=0", free_cnt, alloc_gnt, alloc_tag, N);
    end
    advance();
  endtask

  task automatic test_random();
    bit heavy_alloc;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      heavy_alloc = ((c / 40) % 2) == 0;
      drive(heavy_alloc ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2),
            heavy_alloc ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7),
            $urandom_range(0, N - 1),
            $urandom_range(0, 99) == 0,
            $urandom_range(0, 199) == 0);
      checks++;
      if (alloc_gnt !== m_gnt() || alloc_tag !== LG_N'(m_low()) || free_cnt !== (LG_N+1)'(m_cnt()) ||
          empty !== (m_cnt() == 0) || dbl_free_err !== m_err) begin
        errors++;
        $display("FAIL rand[%0d] got gnt=%b tag=%0d cnt=%0d empty=%b err=%b exp gnt=%b tag=%0d cnt=%0d empty=%b err=%b",
                 c, alloc_gnt, alloc_tag, free_cnt, empty, dbl_free_err,
                 m_gnt(), m_low(), m_cnt(), (m_cnt() == 0), m_err);
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_free[i] = 1'b1;
    m_err      = 1'b0;
    reset      = 1'b1;
    alloc_req  = 1'b0;
    free_valid = 1'b0;
    free_tag   = '0;
    flush      = 1'b0;
    test_reset();
    test_fill();
    test_free_latency();
    test_back_to_back();
    test_flush();
    test_dbl_free();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/free_tag_alloc.md
FREE_TAG_ALLOC -- requirements
Module: free_tag_alloc

Interface
REQ-001 Parameter: LG_N, default 4, log2 of the tag pool size; N = 1 << LG_N; legal range 2..6.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alloc_req  input  1  requester wants one tag this cycle.
REQ-005 alloc_gnt  output  1  combinational; tag granted this cycle.
REQ-006 alloc_tag  output  LG_N  combinational; granted tag index, valid only when alloc_gnt=1.
REQ-007 free_valid  input  1  return one tag this cycle.
REQ-008 free_tag  input  LG_N  index of the returned tag.
REQ-009 flush  input  1  return all tags to the pool.
REQ-010 empty  output  1  registered; no tag free.
REQ-011 free_cnt  output  LG_N+1  registered; number of free tags, 0..N.
REQ-012 dbl_free_err  output  1  sticky error flag (see Configuration).

Function
REQ-013 Internal state: N-bit free bitmap (bit i = 1 means tag i free), free_cnt register, empty register.
REQ-014 alloc_tag = index of the lowest-numbered set bit of the current bitmap; 0 when the bitmap is zero.
REQ-015 alloc_gnt = alloc_req & !empty & !flush & !reset; zero-cycle grant latency.
REQ-016 On a grant, bit alloc_tag clears at the next edge; the tag is unavailable from the next cycle.
REQ-017 On free_valid & !flush, bit free_tag sets at the next edge; no same-cycle bypass, so a freed tag becomes grantable one cycle later at the earliest.
REQ-018 Grant and free in the same cycle: both updates apply; free_cnt is unchanged.
REQ-019 free_cnt next = free_cnt - gnt + (free_valid & bit free_tag currently 0); it saturates by construction and never exceeds N or drops below 0.
REQ-020 empty next = (free_cnt next == 0); empty and free_cnt always agree with the bitmap popcount.
REQ-021 A free of a tag whose bit is already 1 leaves the bitmap and free_cnt unchanged.
REQ-022 flush: at the next edge, bitmap = all ones, free_cnt = N, empty = 0. In the flush cycle alloc_gnt = 0, and any free_valid in that cycle is ignored.
REQ-023 Back-to-back grants on consecutive cycles return strictly the lowest free index each cycle.

Reset
REQ-024 While reset is sampled high: bitmap <= all ones, free_cnt <= N, empty <= 0, dbl_free_err <= 0.
REQ-025 Reset takes priority over flush, alloc and free; alloc_gnt = 0 in any cycle with reset=1.
REQ-026 Reset mid-operation discards all outstanding allocations; no tag is preserved.

Configuration
REQ-027 Macro FREE_TAG_DBL_FREE_CHECK_EN controls double-free detection.
REQ-028 With the macro defined, dbl_free_err sets at the next edge when free_valid & !flush & !reset and bit free_tag is already 1. The flag remains set until reset; flush does not clear it.
REQ-029 Without the macro, dbl_free_err is tied to 0 and no detection logic is built; all other behaviour is identical.

Verification
REQ-030 Reset, then alloc_req=1 for 16 cycles (LG_N=4): grants tags 0,1,...,15 in order; after the last grant empty=1 and free_cnt=0; alloc_req on the 17th cycle gives alloc_gnt=0.
REQ-031 Pool empty; free_tag=5 in cycle t with alloc_req=1: alloc_gnt=0 in t; in t+1 alloc_gnt=1 with alloc_tag=5.
REQ-032 Tags 0-3 allocated; in one cycle allocate and free tag 2 together: the grant is tag 4, then tag 2 is re-granted next; free_cnt is unchanged across the simultaneous cycle.
REQ-033 10 tags allocated; pulse flush together with alloc_req and free_valid: alloc_gnt=0 that cycle; next cycle free_cnt=16, empty=0, alloc_tag=0.
REQ-034 With FREE_TAG_DBL_FREE_CHECK_EN defined, free tag 7 while it is already free: dbl_free_err=1 next cycle and it stays set through a flush; free_cnt stays 16. Without the macro, dbl_free_err stays 0.
REQ-035 Reset asserted mid-sequence with 6 tags held: next cycle free_cnt=16 and the first grant is tag 0.
